// File: rtl/dino_pkg.sv
// Shared definitions for the dino motion controller.
//   - dino_state_e   : motion FSM state encoding
//   - Def*           : default jump profile and timing constants
//   - profile_height : total pixel height climbed by one jump profile
package dino_pkg;

    typedef enum logic [2:0] {
        StRun    = 3'd0,
        StRise   = 3'd1,
        StFall   = 3'd2,
        StSquat  = 3'd3,
        StFrozen = 3'd4
    } dino_state_e;

    localparam int unsigned DefGroundY  = 196;
    localparam int unsigned DefYw       = 9;
    localparam int unsigned DefNReq     = 2;
    localparam int unsigned DefP1       = 10;
    localparam int unsigned DefP2       = 10;
    localparam int unsigned DefP3       = 12;
    localparam int unsigned DefS1       = 6;
    localparam int unsigned DefS2       = 4;
    localparam int unsigned DefS3       = 2;
    localparam int unsigned DefLegTicks = 16;
    localparam int unsigned DefBufTicks = 4;

    function automatic int unsigned profile_height(input int unsigned p1, input int unsigned s1,
                                                   input int unsigned p2, input int unsigned s2,
                                                   input int unsigned p3, input int unsigned s3);
        return p1 * s1 + p2 * s2 + p3 * s3;
    endfunction

endpackage

// File: rtl/dino_motion_ctrl_if.sv
// Signal bundle between the game logic and the dino motion controller.
//   master : drives tick / jump_req / squat_req / crash / restart, observes motion outputs
//   slave  : the motion controller itself
interface dino_motion_ctrl_if #(
    parameter int unsigned YW    = 9,
    parameter int unsigned N_REQ = 2
);
    logic             tick;
    logic [N_REQ-1:0] jump_req;
    logic             squat_req;
    logic             crash;
    logic             restart;
    logic [YW-1:0]    dino_y;
    logic             airborne;
    logic             squatting;
    logic             leg;
    logic             frozen;

    modport master (
        output tick, jump_req, squat_req, crash, restart,
        input  dino_y, airborne, squatting, leg, frozen
    );

    modport slave (
        input  tick, jump_req, squat_req, crash, restart,
        output dino_y, airborne, squatting, leg, frozen
    );
endinterface

// File: rtl/edge_rise.sv
// Registered rising-edge detector.
//   clk, clrn : clock and asynchronous active-low reset
//   i_d       : level input
//   o_pulse   : one-clk pulse, one clk after a 0->1 transition of i_d is sampled
// The first sample after reset only seeds the history, so a level already high at
// reset release never counts as an edge.
module edge_rise (
    input  logic clk,
    input  logic clrn,
    input  logic i_d,
    output logic o_pulse
);
    logic r_prev;
    logic r_armed;
    logic r_pulse;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= i_d;
            r_armed <= 1'b1;
            r_pulse <= r_armed & i_d & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;
endmodule

// File: rtl/dino_motion_ctrl.sv
// Dino sprite motion controller: run / jump (rise+fall profile) / squat / frozen.
//   clk, clrn       : clock and asynchronous active-low reset
//   bus (slave)     : tick (step timebase), jump_req[N_REQ], squat_req, crash, restart in;
//                     dino_y, airborne, squatting, leg, frozen out (all registered)
module dino_motion_ctrl
    import dino_pkg::*;
#(
    parameter int unsigned GROUND_Y  = DefGroundY,
    parameter int unsigned YW        = DefYw,
    parameter int unsigned N_REQ     = DefNReq,
    parameter int unsigned P1        = DefP1,
    parameter int unsigned P2        = DefP2,
    parameter int unsigned P3        = DefP3,
    parameter int unsigned S1        = DefS1,
    parameter int unsigned S2        = DefS2,
    parameter int unsigned S3        = DefS3,
    parameter int unsigned LEG_TICKS = DefLegTicks,
    parameter int unsigned BUF_TICKS = DefBufTicks
) (
    input logic               clk,
    input logic               clrn,
    dino_motion_ctrl_if.slave bus
);
    localparam int unsigned T  = P1 + P2 + P3;
    localparam int unsigned CW = $clog2(T + 1);
    localparam int unsigned LW = (LEG_TICKS > 1) ? $clog2(LEG_TICKS) : 1;

    localparam logic [CW-1:0] CntLast     = CW'(T - 1);
    localparam logic [CW-1:0] CntBufStart = CW'(T - BUF_TICKS);
    localparam logic [CW-1:0] RiseSeg1End = CW'(P1);
    localparam logic [CW-1:0] RiseSeg2End = CW'(P1 + P2);
    localparam logic [CW-1:0] FallSeg1End = CW'(P3);
    localparam logic [CW-1:0] FallSeg2End = CW'(P3 + P2);
    localparam logic [LW-1:0] LegLast     = LW'(LEG_TICKS - 1);
    localparam logic [YW-1:0] GroundY     = YW'(GROUND_Y);

    if (GROUND_Y < profile_height(P1, S1, P2, S2, P3, S3)) begin : gen_bad_profile
        $error("dino_motion_ctrl: GROUND_Y too small for the jump profile");
    end
    if (BUF_TICKS > T) begin : gen_bad_buf
        $error("dino_motion_ctrl: BUF_TICKS exceeds the fall length");
    end

    // Edge detection: one instance for tick, one per jump channel
    logic             w_step;
    logic [N_REQ-1:0] w_jump_pulse;
    logic             w_jump;

    edge_rise u_tick_edge (
        .clk     (clk),
        .clrn    (clrn),
        .i_d     (bus.tick),
        .o_pulse (w_step)
    );

    for (genvar g = 0; g < N_REQ; g++) begin : gen_jump_edge
        edge_rise u_jump_edge (
            .clk     (clk),
            .clrn    (clrn),
            .i_d     (bus.jump_req[g]),
            .o_pulse (w_jump_pulse[g])
        );
    end

    assign w_jump = |w_jump_pulse;

    // State and datapath registers
    dino_state_e r_state;
    logic [YW-1:0] r_y;
    logic [CW-1:0] r_cnt;
    logic [LW-1:0] r_leg_cnt;
    logic          r_leg;
    logic          r_buf;
    logic          r_airborne;
    logic          r_squatting;
    logic          r_frozen;

    dino_state_e w_state_nxt;
    logic [YW-1:0] w_y_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [LW-1:0] w_leg_cnt_nxt;
    logic          w_leg_nxt;
    logic          w_buf_nxt;
    logic          w_buf_hit;
    logic [YW-1:0] w_rise_delta;
    logic [YW-1:0] w_fall_delta;
    logic          w_airborne_nxt;
    logic          w_squatting_nxt;
    logic          w_frozen_nxt;

    // Per-step displacement; the fall walks the rise segments in reverse order
    always_comb begin
        w_rise_delta = YW'(S3);
        if (r_cnt < RiseSeg1End) begin
            w_rise_delta = YW'(S1);
        end else if (r_cnt < RiseSeg2End) begin
            w_rise_delta = YW'(S2);
        end
        w_fall_delta = YW'(S1);
        if (r_cnt < FallSeg1End) begin
            w_fall_delta = YW'(S3);
        end else if (r_cnt < FallSeg2End) begin
            w_fall_delta = YW'(S2);
        end
    end

    // State register (with datapath)
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state   <= StRun;
            r_y       <= GroundY;
            r_cnt     <= '0;
            r_leg_cnt <= '0;
            r_leg     <= 1'b0;
            r_buf     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_y       <= w_y_nxt;
            r_cnt     <= w_cnt_nxt;
            r_leg_cnt <= w_leg_cnt_nxt;
            r_leg     <= w_leg_nxt;
            r_buf     <= w_buf_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_y_nxt       = r_y;
        w_cnt_nxt     = r_cnt;
        w_leg_cnt_nxt = r_leg_cnt;
        w_leg_nxt     = r_leg;
        w_buf_nxt     = r_buf;
        w_buf_hit     = r_buf;

        if (bus.crash) begin
            // Crash wins over everything; all motion state holds
            w_state_nxt = StFrozen;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (w_step) begin
                        if (r_leg_cnt == LegLast) begin
                            w_leg_cnt_nxt = '0;
                            w_leg_nxt     = ~r_leg;
                        end else begin
                            w_leg_cnt_nxt = r_leg_cnt + LW'(1);
                        end
                    end
                    if (w_jump) begin
                        w_state_nxt = StRise;
                        w_cnt_nxt   = '0;
                    end else if (bus.squat_req) begin
                        w_state_nxt = StSquat;
                    end
                end
                StSquat: begin
                    if (w_jump) begin
                        w_state_nxt = StRise;
                        w_cnt_nxt   = '0;
                    end else if (!bus.squat_req) begin
                        w_state_nxt = StRun;
                    end
                end
                StRise: begin
                    if (w_step) begin
                        w_y_nxt = r_y - w_rise_delta;
                        if (r_cnt == CntLast) begin
                            w_state_nxt = StFall;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end
                end
                StFall: begin
                    // Late jump requests are remembered so the next jump starts on landing
                    w_buf_hit = r_buf | (w_jump & (r_cnt >= CntBufStart));
                    w_buf_nxt = w_buf_hit;
                    if (w_step) begin
                        w_y_nxt = r_y + w_fall_delta;
                        if (r_cnt == CntLast) begin
                            w_cnt_nxt   = '0;
                            w_buf_nxt   = 1'b0;
                            w_state_nxt = w_buf_hit ? StRise : StRun;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end
                end
                StFrozen: begin
                    if (bus.restart) begin
                        w_state_nxt   = StRun;
                        w_y_nxt       = GroundY;
                        w_cnt_nxt     = '0;
                        w_leg_cnt_nxt = '0;
                        w_buf_nxt     = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = StRun;
                end
            endcase
        end
    end

    // Output decode from the next state, registered below
    always_comb begin
        w_airborne_nxt  = (w_state_nxt == StRise) || (w_state_nxt == StFall);
        w_squatting_nxt = (w_state_nxt == StSquat);
        w_frozen_nxt    = (w_state_nxt == StFrozen);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_airborne  <= 1'b0;
            r_squatting <= 1'b0;
            r_frozen    <= 1'b0;
        end else begin
            r_airborne  <= w_airborne_nxt;
            r_squatting <= w_squatting_nxt;
            r_frozen    <= w_frozen_nxt;
        end
    end

    assign bus.dino_y    = r_y;
    assign bus.airborne  = r_airborne;
    assign bus.squatting = r_squatting;
    assign bus.leg       = r_leg;
    assign bus.frozen    = r_frozen;
endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Scoreboard bench for dino_motion_ctrl: the driver issues stimulus slots of 4 clks,
// updates a trajectory-table reference model and queues the expected outputs; an
// independent monitor pops and compares them when they fall due.
module tb_dino_motion_ctrl;
    localparam int unsigned G    = 196;
    localparam int unsigned YW   = 9;
    localparam int unsigned NREQ = 2;
    localparam int unsigned P1   = 10;
    localparam int unsigned P2   = 10;
    localparam int unsigned P3   = 12;
    localparam int unsigned S1   = 6;
    localparam int unsigned S2   = 4;
    localparam int unsigned S3   = 2;
    localparam int unsigned LEGT = 16;
    localparam int unsigned BUFT = 4;
    localparam int unsigned T    = P1 + P2 + P3;

    logic clk  = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dino_motion_ctrl_if #(.YW(YW), .N_REQ(NREQ)) bus ();

    dino_motion_ctrl #(
        .GROUND_Y  (G),
        .YW        (YW),
        .N_REQ     (NREQ),
        .P1        (P1),
        .P2        (P2),
        .P3        (P3),
        .S1        (S1),
        .S2        (S2),
        .S3        (S3),
        .LEG_TICKS (LEGT),
        .BUF_TICKS (BUFT)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus.slave)
    );

    // Reference model: jump as a precomputed height table indexed by air step
    typedef enum int {MRun, MAir, MSq, MFrz} mmode_e;
    mmode_e m_mode;
    int     m_y, m_k, m_legc;
    bit     m_leg, m_bflag;
    int     traj[2*T];
    bit     lv_squat, lv_crash, lv_restart;

    typedef struct {
        int due;
        int id;
        int y;
        bit air;
        bit sq;
        bit leg;
        bit frz;
    } exp_t;
    exp_t q[$];
    int   n_push = 0;
    int   checks = 0;
    int   failures = 0;

    function automatic void build_traj();
        int y = G;
        int idx = 0;
        int segp[3] = '{P1, P2, P3};
        int segs[3] = '{S1, S2, S3};
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < segp[s]; i++) begin y -= segs[s]; traj[idx] = y; idx++; end
        for (int s = 2; s >= 0; s--)
            for (int i = 0; i < segp[s]; i++) begin y += segs[s]; traj[idx] = y; idx++; end
    endfunction

    task automatic model_reset();
        m_mode = MRun; m_y = G; m_k = 0; m_legc = 0; m_leg = 0; m_bflag = 0;
    endtask

    // One clk of behaviour given the held levels and this clk's step/jump events
    task automatic model_apply(input bit step, input bit jump);
        if (lv_crash) begin
            m_mode = MFrz;
            return;
        end
        case (m_mode)
            MFrz: if (lv_restart) begin
                m_mode = MRun; m_y = G; m_k = 0; m_legc = 0; m_bflag = 0;
            end
            MRun: begin
                if (step) begin
                    m_legc++;
                    if (m_legc == LEGT) begin m_legc = 0; m_leg = !m_leg; end
                end
                if (jump) begin m_mode = MAir; m_k = 0; end
                else if (lv_squat) m_mode = MSq;
            end
            MSq: begin
                if (jump) begin m_mode = MAir; m_k = 0; end
                else if (!lv_squat) m_mode = MRun;
            end
            MAir: begin
                if (jump && m_k >= int'(2*T - BUFT)) m_bflag = 1;
                if (step) begin
                    m_y = traj[m_k];
                    m_k++;
                    if (m_k == int'(2*T)) begin
                        m_k = 0;
                        if (m_bflag) m_bflag = 0;
                        else m_mode = MRun;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic push(input int due);
        exp_t e;
        e.due = due; e.id = n_push; e.y = m_y;
        e.air = (m_mode == MAir); e.sq = (m_mode == MSq);
        e.leg = m_leg; e.frz = (m_mode == MFrz);
        q.push_back(e);
        n_push++;
    endtask

    // One 4-clk slot: levels held for the slot, tick and jump pulses at its start
    task automatic slot(input bit step, input bit do_jump, input bit ch, input bit squat,
                        input bit crash, input bit restart);
        int c;
        @(posedge clk);
        #1;
        c = cyc;
        bus.tick = step;
        bus.squat_req = squat;
        bus.crash = crash;
        bus.restart = restart;
        if (do_jump) bus.jump_req[ch] = 1'b1;
        lv_squat = squat; lv_crash = crash; lv_restart = restart;
        model_apply(1'b0, 1'b0);
        model_apply(step, do_jump);
        model_apply(1'b0, 1'b0);
        push(c + 3);
        @(posedge clk); #1 bus.jump_req = '0;
        @(posedge clk); #1 bus.tick = 1'b0;
        @(posedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) slot(1'b1, 1'b0, 1'b0, lv_squat, 1'b0, 1'b0);
    endtask

    task automatic jump(input bit ch, input bit step);
        slot(step, 1'b1, ch, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset pulse; with hold_high, tick and a jump request stay high across release
    task automatic do_reset(input bit hold_high);
        @(posedge clk);
        #1;
        clrn = 1'b0;
        bus.tick = hold_high;
        bus.jump_req = hold_high ? 2'b01 : 2'b00;
        bus.squat_req = 1'b0; bus.crash = 1'b0; bus.restart = 1'b0;
        lv_squat = 0; lv_crash = 0; lv_restart = 0;
        model_reset();
        push(cyc);
        repeat (2) @(posedge clk);
        #1 clrn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.tick = 1'b0;
        bus.jump_req = '0;
        push(cyc + 2);
        repeat (2) @(posedge clk);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                checks++;
                if (int'(bus.dino_y) != e.y || bus.airborne != e.air || bus.squatting != e.sq ||
                    bus.leg != e.leg || bus.frozen != e.frz) begin
                    failures++;
                    $display("FAIL snap%0d got y=%0d air=%0b sq=%0b leg=%0b frz=%0b want y=%0d air=%0b sq=%0b leg=%0b frz=%0b",
                             e.id, bus.dino_y, bus.airborne, bus.squatting, bus.leg, bus.frozen,
                             e.y, e.air, e.sq, e.leg, e.frz);
                end
            end
        end
    end

    // Driver
    initial begin
        bit sq;
        int waited;
        bus.tick = 1'b0; bus.jump_req = '0; bus.squat_req = 1'b0;
        bus.crash = 1'b0; bus.restart = 1'b0;
        lv_squat = 0; lv_crash = 0; lv_restart = 0;
        build_traj();
        model_reset();

        // Power-up reset with tick/jump already high at release: no step, no jump
        do_reset(1'b1);

        // Full jump on channel 0, then a little running
        jump(1'b0, 1'b0);
        ticks(64);
        ticks(3);

        // Late jump on channel 1 is buffered into an immediate re-jump; early one ignored
        jump(1'b1, 1'b0);
        ticks(62);
        jump(1'b1, 1'b0);
        ticks(2);
        ticks(42);
        jump(1'b1, 1'b0);
        ticks(22);
        ticks(2);

        // Squat, then release squat together with a jump
        slot(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        slot(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        slot(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(64);

        // Crash mid-rise, long freeze, crash+restart, then restart alone
        jump(1'b0, 1'b0);
        ticks(15);
        slot(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(100);
        slot(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        slot(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        ticks(2);

        // Reset mid-rise
        jump(1'b0, 1'b0);
        ticks(5);
        do_reset(1'b0);

        // Leg animation over 48 running ticks, then none while airborne
        ticks(48);
        jump(1'b0, 1'b1);
        ticks(64);

        // Randomised play
        sq = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) < 10) sq = !sq;
            slot($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 12, 1'($urandom_range(0, 1)),
                 sq, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 10);
        end

        waited = 0;
        while (q.size() > 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
